// File: rtl/serial_cmd_if.sv
// serial_cmd_if: byte handshake between the serial receiver/transmitter and the command decoder
// rx_data/rx_byte_valid/rx_read: received byte, level-valid, one-cycle consume pulse
// tx_data/tx_data_ready/tx_data_copied: byte to send, held-ready, one-cycle accept pulse
interface serial_cmd_if;
  logic [7:0] rx_data;
  logic       rx_byte_valid;
  logic       rx_read;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_data_copied;
  modport master (output rx_data, rx_byte_valid, tx_data_copied, input rx_read, tx_data, tx_data_ready);
  modport slave  (input rx_data, rx_byte_valid, tx_data_copied, output rx_read, tx_data, tx_data_ready);
endinterface

// File: rtl/serial_cmd_decoder.sv
// serial_cmd_decoder: parses 5-byte command frames, executes register read/write, returns 5-byte responses
// clk: system clock; rst: asynchronous active-low reset
// bus: serial_cmd_if slave side (receiver bytes in, transmitter bytes out)
// led_bus: mirror of register 1; cmd_count: OK commands (wrapping); frame_err: one-cycle error pulse
module serial_cmd_decoder #(
  parameter int         REG_COUNT           = 8,
  parameter logic [7:0] DEVICE_ID           = 8'hC4,
  parameter int         BYTE_TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0] SOF_BYTE            = 8'hA5,
  parameter logic [7:0] RSP_BYTE            = 8'h5A
) (
  input  logic             clk,
  input  logic             rst,
  serial_cmd_if.slave      bus,
  output logic [7:0]       led_bus,
  output logic [7:0]       cmd_count,
  output logic             frame_err
);
  localparam int AW = $clog2(REG_COUNT);
  typedef enum logic [2:0] {IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CRC, EXEC, SEND} state_t;
  state_t      state;
  logic [7:0]  regs [REG_COUNT];
  logic [7:0]  cmd, addr, data, crc, status, rdata;
  logic [2:0]  idx;
  logic [31:0] idle_cnt;
  logic        in_get, accept, timeout, is_read, is_write, addr_ok;
  logic [7:0]  rd_val, status_n, rdata_n, rsp;
  logic [AW-1:0] a;
  always_comb begin
    in_get   = state inside {GET_CMD, GET_ADDR, GET_DATA, GET_CRC};
    accept   = bus.rx_byte_valid && !bus.rx_read && (in_get || state == IDLE);
    timeout  = in_get && !accept && idle_cnt == 32'(BYTE_TIMEOUT_CYCLES - 1);
    is_read  = cmd == 8'h01;
    is_write = cmd == 8'h02;
    a        = addr[AW-1:0];
    addr_ok  = addr < 8'(REG_COUNT) && !(is_write && addr == 8'h00);
    rd_val   = addr == 8'h00 ? DEVICE_ID : regs[a];
    // status priority: CRC, then command, then address
    status_n = crc != (cmd ^ addr ^ data) ? 8'h01 :
               !(is_read || is_write)     ? 8'h02 :
               !addr_ok                   ? 8'h03 : 8'h00;
    rdata_n  = status_n != 8'h00 ? 8'h00 : is_write ? data : rd_val;
    rsp      = idx == 3'd0 ? RSP_BYTE :
               idx == 3'd1 ? status :
               idx == 3'd2 ? addr :
               idx == 3'd3 ? rdata : status ^ addr ^ rdata;
  end
  assign led_bus = regs[1];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      bus.rx_read       <= 1'b0;
      bus.tx_data       <= 8'h00;
      bus.tx_data_ready <= 1'b0;
      cmd_count         <= 8'h00;
      frame_err         <= 1'b0;
      idx               <= 3'd0;
      idle_cnt          <= 32'd0;
      cmd               <= 8'h00;
      addr              <= 8'h00;
      data              <= 8'h00;
      crc               <= 8'h00;
      status            <= 8'h00;
      rdata             <= 8'h00;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
    end else begin
      bus.rx_read <= accept;
      frame_err   <= timeout;
      idle_cnt    <= (!in_get || accept || timeout) ? 32'd0 : idle_cnt + 32'd1;
      case (state)
        IDLE:     if (accept && bus.rx_data == SOF_BYTE) state <= GET_CMD;
        GET_CMD:  if (accept) begin cmd  <= bus.rx_data; state <= GET_ADDR; end
        GET_ADDR: if (accept) begin addr <= bus.rx_data; state <= GET_DATA; end
        GET_DATA: if (accept) begin data <= bus.rx_data; state <= GET_CRC; end
        GET_CRC:  if (accept) begin crc  <= bus.rx_data; state <= EXEC; end
        EXEC: begin
          status    <= status_n;
          rdata     <= rdata_n;
          frame_err <= status_n != 8'h00;
          if (status_n == 8'h00) begin
            cmd_count <= cmd_count + 8'd1;
            if (is_write) regs[a] <= data;
          end
          idx               <= 3'd0;
          bus.tx_data       <= RSP_BYTE;
          bus.tx_data_ready <= 1'b1;
          state             <= SEND;
        end
        SEND: begin
          // ready drops for one cycle after each copy, then the next byte is presented
          if (bus.tx_data_ready && bus.tx_data_copied) begin
            bus.tx_data_ready <= 1'b0;
            idx               <= idx + 3'd1;
            if (idx == 3'd4) state <= IDLE;
          end else if (!bus.tx_data_ready) begin
            bus.tx_data_ready <= 1'b1;
            bus.tx_data       <= rsp;
          end
        end
        default: state <= IDLE;
      endcase
      if (timeout) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_cmd_decoder.sv
// tb_serial_cmd_decoder: directed and randomized frames checked against a behavioural register-file model
module tb_serial_cmd_decoder;
  localparam int TO = 100;
  localparam int RC = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] led_bus, cmd_count;
  logic frame_err;
  int tests = 0;
  int fails = 0;
  int err_pulses = 0;
  logic [7:0] mreg [RC];
  logic [7:0] mcount;
  serial_cmd_if bus();
  serial_cmd_decoder #(.BYTE_TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .led_bus(led_bus), .cmd_count(cmd_count), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data = b;
    bus.rx_byte_valid = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!bus.rx_read && n < 50);
    bus.rx_byte_valid = 1'b0;
    check("rx_read", 32'(bus.rx_read), 32'd1);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input string tag, input bit lat);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.tx_data_ready && n < 50);
    check({tag, "_ready"}, 32'(bus.tx_data_ready), 32'd1);
    if (lat) check({tag, "_latency"}, n, 32'd1);
    check({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.tx_data_copied = 1'b1;
    @(posedge clk); #1;
    bus.tx_data_copied = 1'b0;
    check({tag, "_drop"}, 32'(bus.tx_data_ready), 32'd0);
  endtask

  // reference: status/rdata straight from the frame rules, applied to the model register file
  task automatic expect_rsp(input logic [7:0] c, a, d, k, output logic [7:0] e [5]);
    logic [7:0] st, rd;
    if (k != (c ^ a ^ d)) st = 8'h01;
    else if (c != 8'h01 && c != 8'h02) st = 8'h02;
    else if (int'(a) >= RC || (c == 8'h02 && a == 8'h00)) st = 8'h03;
    else st = 8'h00;
    rd = 8'h00;
    if (st == 8'h00) begin
      mcount = mcount + 8'd1;
      if (c == 8'h02) mreg[a[2:0]] = d;
      rd = a == 8'h00 ? 8'hC4 : mreg[a[2:0]];
    end
    e = '{8'h5A, st, a, rd, st ^ a ^ rd};
  endtask

  task automatic run_frame(input logic [7:0] c, a, d, k, input string tag);
    logic [7:0] e [5];
    int e0 = err_pulses;
    expect_rsp(c, a, d, k, e);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(d);
    send_byte(k);
    for (int i = 0; i < 5; i++) recv_byte(e[i], $sformatf("%s_b%0d", tag, i), i == 0);
    check({tag, "_cmd_count"}, 32'(cmd_count), 32'(mcount));
    check({tag, "_led_bus"}, 32'(led_bus), 32'(mreg[1]));
    check({tag, "_frame_err"}, err_pulses - e0, (e[1] != 8'h00) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int e0;
    bit seen;
    logic [7:0] c, a, d, k, g;
    bus.rx_data = 8'h00;
    bus.rx_byte_valid = 1'b0;
    bus.tx_data_copied = 1'b0;
    mcount = 8'h00;
    for (int i = 0; i < RC; i++) mreg[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_ready", 32'(bus.tx_data_ready), 32'd0);
    check("rst_rx_read", 32'(bus.rx_read), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_led", 32'(led_bus), 32'd0);
    check("rst_count", 32'(cmd_count), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_frame(8'h02, 8'h01, 8'h3C, 8'h3F, "t1_write");
    run_frame(8'h01, 8'h01, 8'h00, 8'h00, "t2_read1");
    run_frame(8'h01, 8'h00, 8'h00, 8'h01, "t2_read_id");
    run_frame(8'h02, 8'h01, 8'h77, 8'h00, "t3_badcrc");
    run_frame(8'h01, 8'h09, 8'h00, 8'h08, "t4_badaddr");
    run_frame(8'h02, 8'h00, 8'h11, 8'h13, "t4_wr_reg0");
    run_frame(8'h07, 8'h02, 8'h00, 8'h05, "t4_badcmd");
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h33;
        send_byte(g);
      end
      a = 8'($urandom_range(0, 9));
      d = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: c = 8'h01;
        4, 5, 6, 7: c = 8'h02;
        default: c = 8'($urandom);
      endcase
      k = c ^ a ^ d;
      if ($urandom_range(0, 5) == 0) k = k ^ 8'($urandom_range(1, 255));
      run_frame(c, a, d, k, $sformatf("rnd%0d", it));
    end
    e0 = err_pulses;
    seen = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO / 2) begin @(posedge clk); #1; if (bus.tx_data_ready) seen = 1'b1; end
    check("t5_no_early_timeout", err_pulses - e0, 32'd0);
    repeat (TO / 2 + 20) begin @(posedge clk); #1; if (bus.tx_data_ready) seen = 1'b1; end
    check("t5_timeout_err", err_pulses - e0, 32'd1);
    check("t5_no_tx", 32'(seen), 32'd0);
    send_byte(8'h33);
    run_frame(8'h01, 8'h00, 8'h00, 8'h01, "t5_resync");
    run_frame(8'h02, 8'h01, 8'h3C, 8'h3F, "t6_prep");
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    recv_byte(8'h5A, "t6_b0", 1'b1);
    recv_byte(8'h00, "t6_b1", 1'b0);
    e0 = 0;
    do begin @(posedge clk); #1; e0++; end while (!bus.tx_data_ready && e0 < 50);
    check("t6_third_ready", 32'(bus.tx_data_ready), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_rst_ready", 32'(bus.tx_data_ready), 32'd0);
    check("t6_rst_led", 32'(led_bus), 32'd0);
    check("t6_rst_count", 32'(cmd_count), 32'd0);
    mcount = 8'h00;
    for (int i = 0; i < RC; i++) mreg[i] = 8'h00;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("t6_no_resume", 32'(bus.tx_data_ready), 32'd0);
    run_frame(8'h01, 8'h01, 8'h00, 8'h01, "t6_read_after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
